// File: rtl/shift_pkg.sv
// Shared encodings for the barrel-shifter datapath: sequencer, shifter and display decoder.
package shift_pkg;

  localparam logic [1:0] OP_ROTL = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  // 1 s per auto step at a 100 MHz system clock
  localparam int unsigned DEF_TICK_DIV = 100_000_000;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_HOLD   = 2'b10
  } seq_state_e;

  // Operation codes advance in encoding order and wrap from shr back to rotl.
  function automatic logic [1:0] op_advance(input logic [1:0] op_cur);
    return op_cur + 2'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick after every TICK_DIV enabled cycles.
// clr has priority over en and suppresses the tick of that cycle.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A single-bit counter keeps TICK_DIV=1 legal (terminal count is then 0).
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_tc;

  assign at_tc = (cnt_q == TC);
  assign tick  = en & ~clr & at_tc;

  // Next count: clear, wrap at terminal count, or hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_tc ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for the 16-bit barrel shifter: assembles the operand from byte writes
// and drives shift amount / op code, either from switches or from an auto stepper.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_MANUAL | shamt/op track sel_in/op_in each cycle, prescaler held at 0
// ST_AUTO   | prescaler runs; each tick bumps shamt, wrap bumps op
// ST_HOLD   | prescaler, shamt and op frozen; load edge still preloads
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter bit          CYCLE_OP = 1'b1,
  localparam int unsigned SHW     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode,
  input  logic               hold,
  input  logic               wr_en,
  input  logic               in_select,
  input  logic [WIDTH/2-1:0] in,
  input  logic [1:0]         op_in,
  input  logic [SHW-1:0]     sel_in,
  input  logic               load,
  output logic [WIDTH-1:0]   data_out,
  output logic [SHW-1:0]     shamt,
  output logic [1:0]         op,
  output logic               step,
  output logic [1:0]         state_out
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam logic [SHW-1:0] SHAMT_MAX = SHW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic             load_q;
  logic             load_edge;
  logic             step_c;
  logic             pre_en, pre_clr, pre_tick;

  assign load_edge = load & ~load_q;

  // The prescaler only runs in AUTO with nothing overriding it; any exit,
  // a preload edge, or manual tracking keeps it parked at zero.
  assign pre_en  = (state_q == ST_AUTO) & mode & ~hold & ~load_edge;
  assign pre_clr = (state_q == ST_MANUAL) | ~mode | load_edge;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pre_en),
    .clr     (pre_clr),
    .tick    (pre_tick)
  );

  // Byte assembly; independent of mode and of auto stepping.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      if (in_select) begin
        data_d[WIDTH-1:HALF] = in;
      end else begin
        data_d[HALF-1:0] = in;
      end
    end
  end

  // Next-state, shift amount, op code and step pulse.
  always_comb begin
    state_d = state_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    step_c  = 1'b0;
    unique case (state_q)
      ST_MANUAL: begin
        op_d = op_in;
        if (mode) begin
          // Entering auto keeps the current shift amount as the start point.
          state_d = ST_AUTO;
        end else begin
          shamt_d = sel_in;
        end
      end
      ST_AUTO, ST_HOLD: begin
        if (!mode) begin
          state_d = ST_MANUAL;
          shamt_d = sel_in;
          op_d    = op_in;
        end else begin
          state_d = hold ? ST_HOLD : ST_AUTO;
          if (load_edge) begin
            // Preload beats a coincident tick: no step, no op advance.
            shamt_d = sel_in;
          end else if (pre_tick) begin
            step_c  = 1'b1;
            shamt_d = (shamt_q == SHAMT_MAX) ? '0 : shamt_q + 1'b1;
            if (CYCLE_OP && (shamt_q == SHAMT_MAX)) begin
              op_d = op_advance(op_q);
            end
          end
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_MANUAL;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= OP_ROTL;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      load_q  <= load;
    end
  end

  assign data_out  = data_q;
  assign shamt     = shamt_q;
  assign op        = op_q;
  assign step      = step_c;
  assign state_out = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int TDIV = 4;

  logic        clk;
  logic        reset_n;
  logic        mode, hold, wr_en, in_select, load;
  logic [7:0]  in_b;
  logic [1:0]  op_in;
  logic [3:0]  sel_in;
  logic [15:0] data_out;
  logic [3:0]  shamt;
  logic [1:0]  op;
  logic        step;
  logic [1:0]  state_out;

  shift_sequencer #(.WIDTH(16), .TICK_DIV(TDIV), .CYCLE_OP(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .hold      (hold),
    .wr_en     (wr_en),
    .in_select (in_select),
    .in        (in_b),
    .op_in     (op_in),
    .sel_in    (sel_in),
    .load      (load),
    .data_out  (data_out),
    .shamt     (shamt),
    .op        (op),
    .step      (step),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic [15:0] data;
    logic [3:0]  shamt;
    logic [1:0]  op;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model: 0 manual, 1 auto, 2 hold
  int m_st, m_shamt, m_op, m_data, m_cnt;
  bit m_load_prev;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic model_reset();
    m_st = 0; m_shamt = 0; m_op = 0; m_data = 0; m_cnt = 0; m_load_prev = 0;
  endtask

  // Compute this cycle's step and post-edge outputs from the current inputs, push, advance a cycle.
  task automatic go();
    exp_t e;
    int stp;
    bit ledge;
    stp = 0;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (wr_en) begin
        if (in_select) m_data = (m_data % 256) + int'(in_b) * 256;
        else           m_data = (m_data / 256) * 256 + int'(in_b);
      end
      ledge = load && !m_load_prev;
      if (m_st == 0) begin
        m_op  = op_in;
        m_cnt = 0;
        if (mode) m_st = 1;
        else m_shamt = sel_in;
      end else if (!mode) begin
        m_st = 0; m_cnt = 0; m_shamt = sel_in; m_op = op_in;
      end else begin
        int prev_st;
        prev_st = m_st;
        m_st = hold ? 2 : 1;
        if (ledge) begin
          m_shamt = sel_in; m_cnt = 0;
        end else if (prev_st == 1 && !hold) begin
          m_cnt++;
          if (m_cnt == TDIV) begin
            m_cnt = 0;
            stp = 1;
            if (m_shamt == 15) m_op = (m_op + 1) % 4;
            m_shamt = (m_shamt + 1) % 16;
          end
        end
      end
      m_load_prev = load;
    end
    e.step = stp[0]; e.data = m_data[15:0]; e.shamt = m_shamt[3:0];
    e.op = m_op[1:0]; e.st = m_st[1:0];
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: step is judged mid-cycle, registers just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("step", step, e.step);
        @(posedge clk);
        #1;
        chk("data_out", data_out, e.data);
        chk("shamt", shamt, e.shamt);
        chk("op", op, e.op);
        chk("state_out", state_out, e.st);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    wr_en = 0; in_select = 0; in_b = 0; load = 0; hold = 0;
  endtask

  initial begin
    int steps;
    reset_n = 0; mode = 0; op_in = 0; sel_in = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    go(); go();
    chk("reset_state", state_out, 0);
    chk("reset_data", data_out, 0);
    reset_n = 1;

    // 1: byte assembly
    wr_en = 1; in_select = 1; in_b = 8'h7F; go();
    chk("upper_byte", data_out, 16'h7F00);
    in_select = 0; in_b = 8'hFF; go();
    wr_en = 0;
    chk("assembled", data_out, 16'h7FFF);

    // 2: manual tracking
    sel_in = 4'h1; op_in = 2'b01; go();
    chk("man_shamt", shamt, 1);
    chk("man_op", op, 1);
    sel_in = 4'hA; go();
    chk("man_shamt_a", shamt, 4'hA);

    // 3: auto stepping with op wrap
    sel_in = 4'hE; go();
    mode = 1; op_in = 2'b10; go();
    steps = 0;
    for (int i = 0; i < 80; i++) begin
      #2; if (step) steps++;
      go();
    end
    chk("auto_steps", steps, 20);
    chk("op_wrapped", op, 2'b00);

    // 4: preload on the tick cycle, load held high
    for (int i = 0; i < 8 && m_cnt != TDIV - 1; i++) go();
    sel_in = 4'd5; load = 1;
    #2; chk("load_no_step", step, 0);
    go();
    chk("preload", shamt, 5);
    for (int i = 0; i < 19; i++) go();
    load = 0; go();

    // 5: hold freezes everything
    hold = 1;
    for (int i = 0; i < 10; i++) go();
    chk("hold_state", state_out, 2);
    hold = 0;
    for (int i = 0; i < 8; i++) go();

    // 6: async reset mid-auto
    sel_in = 4'd9; load = 1; go();
    load = 0; go();
    reset_n = 0;
    #1;
    chk("async_data", data_out, 0);
    chk("async_shamt", shamt, 0);
    chk("async_state", state_out, 0);
    go();
    reset_n = 1; mode = 1;
    for (int i = 0; i < 8; i++) go();

    // random phase
    for (int i = 0; i < 600; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      mode      = ($urandom_range(0, 11) != 0);
      hold      = ($urandom_range(0, 6) == 0);
      load      = ($urandom_range(0, 4) == 0);
      wr_en     = $urandom_range(0, 1);
      in_select = $urandom_range(0, 1);
      in_b      = 8'($urandom);
      op_in     = 2'($urandom);
      sel_in    = 4'($urandom);
      go();
    end
    reset_n = 1; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Control block that sequences the 16-bit barrel shifter datapath. It assembles the 16-bit operand from two 8-bit byte writes and drives shift amount and operation code to the shifter. In manual mode it mirrors the switch settings. In auto mode it steps the shift amount on a prescaled tick and advances the operation code on wrap. It sits between the board inputs (switches/buttons, already synchronised) and the shifter/seven-segment path.

Parameters:
WIDTH, 16, operand width; shift amount width SHW = $clog2(WIDTH)
TICK_DIV, 100_000_000, clk cycles per auto step (1 s at 100 MHz); benches override to 4
CYCLE_OP, 1, 1 = advance op on shift-amount wrap in auto mode; 0 = op held

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
mode  in  1  0 = manual, 1 = auto
hold  in  1  auto mode: freeze prescaler while high
wr_en  in  1  byte write strobe (level, one write per cycle)
in_select  in  1  1 = upper byte, 0 = lower byte
in  in  WIDTH/2  byte data
op_in  in  2  00 rotl, 01 rotr, 10 shl, 11 shr
sel_in  in  SHW  manual shift amount / auto preload value
load  in  1  auto mode preload request (rising-edge detected internally)
data_out  out  WIDTH  assembled operand to shifter
shamt  out  SHW  shift amount to shifter
op  out  2  operation code to shifter
step  out  1  one-cycle pulse on each auto step
state_out  out  2  00 MANUAL, 01 AUTO, 10 HOLD

Behaviour:
- Reset (async assert, sync release): data_out=0, shamt=0, op=00, step=0, state MANUAL, prescaler=0, load edge register=0.
- Byte write, any state: on a cycle with wr_en=1, in_select=1 loads data_out[15:8]<=in; in_select=0 loads data_out[7:0]<=in. Visible the next cycle. The other byte is unchanged.
- MANUAL: each cycle shamt<=sel_in and op<=op_in (1-cycle latency). load is ignored; only its edge register updates. step=0.
- MANUAL->AUTO when mode=1. On entry the prescaler is cleared, op<=op_in, and shamt keeps its current value.
- AUTO:
  - The prescaler counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1: prescaler<=0, step=1, shamt<=shamt+1 mod WIDTH.
  - If shamt was WIDTH-1 and CYCLE_OP=1, op<=op+1 mod 4 (11 wraps to 00).
- AUTO->HOLD when hold=1. In HOLD the prescaler, shamt and op are frozen and step=0. HOLD->AUTO when hold=0; counting resumes from the frozen value.
- Load in AUTO or HOLD: a rising edge of load (load=1, previous sample 0) sets shamt<=sel_in and clears the prescaler. If a tick coincides, load wins: no step, no op advance. A held-high load counts once.
- mode=0 in AUTO or HOLD -> MANUAL next cycle. The prescaler is cleared and manual tracking resumes that cycle.
- mode and hold both high on MANUAL exit -> AUTO first, then HOLD the following cycle.
- Byte writes are independent of ticks. Both may occur in the same cycle.
- Async reset mid-operation aborts immediately to reset values. No partial byte write survives.
- TICK_DIV=1 is legal: step on every AUTO cycle.

Decomposition:
- Shared package shift_pkg: op encodings (OP_ROTL=2'b00, OP_ROTR=2'b01, OP_SHL=2'b10, OP_SHR=2'b11), state encodings (ST_MANUAL, ST_AUTO, ST_HOLD), and a default TICK_DIV constant. The shifter and display decoder also use this package.
- One sub-module: tick_prescaler. It takes clk, reset_n, en and clr, and produces a single-cycle tick every TICK_DIV enabled cycles.
- The FSM, byte register and load edge detect stay in shift_sequencer.

Test Plan:
1. Reset, then wr_en with in_select=1, in=8'h7F, then in_select=0, in=8'hFF -> data_out=16'h7FFF; each byte changes one cycle after its write.
2. Manual mode, sel_in=4'h1, op_in=01 -> shamt=1, op=01 next cycle. Change sel_in to 4'hA -> shamt=A one cycle later; step stays 0.
3. TICK_DIV=4, mode=1, shamt starting at 4'hE, op_in=10 -> step every 4 cycles. shamt goes E,F,0; op changes 10->11 on the F->0 step. Repeat from op=11 -> op wraps to 00.
4. Auto mode, sel_in=5, load held high 20 cycles, with the rising edge on the tick cycle -> shamt=5, no step that cycle, exactly one preload, next step 4 cycles later gives shamt=6.
5. Auto mode, hold=1 for 10 cycles -> state_out=10, shamt/op/step frozen. On release, the next step occurs after the remaining prescaler count.
6. Assert reset_n=0 mid-auto with data_out=16'h7FFF, shamt=9 -> all outputs 0 and state MANUAL in the same cycle. After release with mode=1 -> AUTO, first step after 4 cycles.
